// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
// Shared definitions for the fetch sequencer, the assembler tests and the
// datapath decoder: opcode constants, sequencer state encoding and PC width.
package fetch_sequencer_pkg;

  localparam int PC_W = 8;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_HALT     = 8'hFF;
  localparam logic [3:0] OPC_BZ_IMM  = 4'b0111;
  localparam logic [3:0] OPC_BNZ_IMM = 4'b1010;
  localparam logic [3:0] OPC_BNZ_REG = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Immediate branch targets are the 4-bit field scaled to an even address.
  function automatic logic [PC_W-1:0] imm_target(input logic [3:0] imm);
    return {3'b000, imm, 1'b0};
  endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_logic.sv
// next_pc_logic
// Combinational decode of the instruction register and selection of the
// next program counter.
// Ports:
//   ir         in   8  instruction register
//   pc         in   8  current program counter
//   acc_zero   in   1  datapath ACC==0 flag
//   reg0_value in   8  register 0, indirect branch target source
//   next_pc    out  8  branch target when taken, otherwise pc+PC_STEP
//   is_branch  out  1  IR is one of the three branch forms
//   is_halt    out  1  IR is HALT
//   is_nop     out  1  IR is NOP
module next_pc_logic
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_STEP = 2
) (
  input  logic [7:0]      ir,
  input  logic [PC_W-1:0] pc,
  input  logic            acc_zero,
  input  logic [7:0]      reg0_value,
  output logic [PC_W-1:0] next_pc,
  output logic            is_branch,
  output logic            is_halt,
  output logic            is_nop
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] target;
  logic            taken;

  // Indirect targets are forced even, so register 0 bit 0 never matters.
  logic unused_reg0_lsb;
  assign unused_reg0_lsb = reg0_value[0];

  // Sequential advance wraps naturally at the 8-bit boundary.
  assign seq_pc = pc + STEP;

  always_comb begin
    is_nop    = (ir == OP_NOP);
    is_halt   = (ir == OP_HALT);
    is_branch = 1'b0;
    taken     = 1'b0;
    target    = imm_target(ir[3:0]);
    case (ir[7:4])
      OPC_BZ_IMM: begin
        is_branch = 1'b1;
        taken     = acc_zero;
      end
      OPC_BNZ_IMM: begin
        is_branch = 1'b1;
        taken     = !acc_zero;
      end
      OPC_BNZ_REG: begin
        is_branch = 1'b1;
        taken     = !acc_zero;
        target    = {reg0_value[7:1], 1'b0};
      end
      default: ;
    endcase
    next_pc = taken ? target : seq_pc;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-memory initiator: owns the PC, fetches one byte per
// instruction, resolves NOP/branch/HALT locally and issues everything else
// to the execute datapath over valid/ready.
// Ports:
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   start        in   1  begin execution from IDLE or HALT
//   pc_address   out  8  fetch address (the PC register)
//   instr_in     in   8  instruction from memory at pc_address
//   issue_valid  out  1  issue_instr holds a datapath instruction
//   issue_instr  out  8  instruction register
//   issue_ready  in   1  datapath accept
//   acc_zero     in   1  datapath ACC==0 flag
//   reg0_value   in   8  register 0 for indirect branches
//   halted       out  1  in HALT
//   busy         out  1  in FETCH or EXEC
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         PC_STEP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] pc_address,
  input  logic [7:0] instr_in,
  output logic       issue_valid,
  output logic [7:0] issue_instr,
  input  logic       issue_ready,
  input  logic       acc_zero,
  input  logic [7:0] reg0_value,
  output logic       halted,
  output logic       busy
);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [7:0]      ir_reg, ir_next;

  logic [PC_W-1:0] npc;
  logic            is_branch, is_halt, is_nop, is_datapath;

  next_pc_logic #(
    .PC_STEP (PC_STEP)
  ) u_next_pc (
    .ir         (ir_reg),
    .pc         (pc_reg),
    .acc_zero   (acc_zero),
    .reg0_value (reg0_value),
    .next_pc    (npc),
    .is_branch  (is_branch),
    .is_halt    (is_halt),
    .is_nop     (is_nop)
  );

  assign is_datapath = !(is_branch || is_halt || is_nop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= 8'h00;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          pc_next    = RESET_PC;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_next    = instr_in;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        // HALT wins over everything; start is not looked at while busy.
        if (is_halt) begin
          state_next = ST_HALT;
        end else if (is_nop || is_branch) begin
          pc_next    = npc;
          state_next = ST_FETCH;
        end else if (issue_ready) begin
          // For datapath instructions npc is always the sequential address.
          pc_next    = npc;
          state_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (start) begin
          pc_next    = RESET_PC;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs come only from state and IR, so reset clears them at once and
  // instr_in never reaches an output combinationally.
  assign pc_address  = pc_reg;
  assign issue_instr = ir_reg;
  assign issue_valid = (state_reg == ST_EXEC) && is_datapath;
  assign halted      = (state_reg == ST_HALT);
  assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_EXEC);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pc_address;
  logic [7:0] instr_in;
  logic       issue_valid;
  logic [7:0] issue_instr;
  logic       issue_ready = 1'b0;
  logic       acc_zero = 1'b1;
  logic [7:0] reg0_value = 8'h00;
  logic       halted;
  logic       busy;

  logic [7:0] mem [256];
  assign instr_in = mem[pc_address];

  fetch_sequencer #(.RESET_PC(8'h00), .PC_STEP(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc_address  (pc_address),
    .instr_in    (instr_in),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .issue_ready (issue_ready),
    .acc_zero    (acc_zero),
    .reg0_value  (reg0_value),
    .halted      (halted),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_halt;
    logic [7:0] pc;
    logic [7:0] instr;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        ev;
  bit         mon_en = 0;
  bit         rdy_rand = 0;
  bit         halt_seen = 0;
  bit         hs_pending = 0;
  logic [7:0] hs_instr = 8'h00;
  bit         prev_stall = 0;
  logic [7:0] prev_instr = 8'h00;
  logic [7:0] prev_pc = 8'h00;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Datapath stand-in: the flag an accepted instruction leaves behind.
  function automatic bit acc_after(input logic [7:0] ins);
    return ins[1:0] == 2'b00;
  endfunction

  // Instruction-level interpreter of the program in mem.
  task automatic build_model();
    logic [7:0] pc;
    logic [7:0] ins;
    bit         az;
    int         steps;
    ev_t        e;
    pc = 8'h00;
    az = 1'b1;
    steps = 0;
    exp_q.delete();
    while (steps < 400 && exp_q.size() < 40) begin
      ins = mem[pc];
      steps++;
      if (ins == 8'h00) begin
        pc = 8'(pc + 2);
      end else if (ins == 8'hFF) begin
        e.is_halt = 1; e.pc = pc; e.instr = ins;
        exp_q.push_back(e);
        break;
      end else if (ins[7:4] == 4'h7) begin
        pc = az ? {3'b000, ins[3:0], 1'b0} : 8'(pc + 2);
      end else if (ins[7:4] == 4'hA) begin
        pc = !az ? {3'b000, ins[3:0], 1'b0} : 8'(pc + 2);
      end else if (ins[7:4] == 4'h8) begin
        pc = !az ? (reg0_value & 8'hFE) : 8'(pc + 2);
      end else begin
        e.is_halt = 0; e.pc = pc; e.instr = ins;
        exp_q.push_back(e);
        az = acc_after(ins);
        pc = 8'(pc + 2);
      end
    end
  endtask

  // Monitor: handshakes and HALT entry, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && issue_valid && issue_ready) begin
      hs_pending = 1;
      hs_instr = issue_instr;
    end
    if (mon_en && rst_n) begin
      if (prev_stall) begin
        check8("stall_valid", {7'b0, issue_valid}, 8'h01);
        check8("stall_instr", issue_instr, prev_instr);
        check8("stall_pc", pc_address, prev_pc);
      end
      prev_stall = issue_valid && !issue_ready;
      prev_instr = issue_instr;
      prev_pc = pc_address;
      if (issue_valid && issue_ready) begin
        $display("issue pc=%h instr=%h", pc_address, issue_instr);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_issue actual=%h expected=none", issue_instr);
        end else begin
          ev = exp_q.pop_front();
          if (ev.is_halt) begin
            failures++;
            $display("FAIL event_kind actual=issue expected=halt");
          end
          check8("issue_pc", pc_address, ev.pc);
          check8("issue_instr", issue_instr, ev.instr);
        end
      end
      if (halted && !halt_seen) begin
        halt_seen = 1;
        $display("halt pc=%h", pc_address);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_halt actual=%h expected=none", pc_address);
        end else begin
          ev = exp_q.pop_front();
          if (!ev.is_halt) begin
            failures++;
            $display("FAIL event_kind actual=halt expected=issue");
          end
          check8("halt_pc", pc_address, ev.pc);
        end
      end
    end
  end

  // Datapath side: flag update after each accept, random ready.
  initial forever begin
    @(posedge clk);
    #1;
    if (hs_pending) begin
      acc_zero = acc_after(hs_instr);
      hs_pending = 0;
    end
    if (rdy_rand) issue_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    hs_pending = 0;
    acc_zero = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_program(input int budget);
    int cyc;
    build_model();
    reset_dut();
    step();
    halt_seen = 0;
    prev_stall = 0;
    mon_en = 1;
    rdy_rand = 1;
    pulse_start();
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      step();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL run_timeout actual=%0d_pending expected=0_pending", exp_q.size());
    end
    mon_en = 0;
    rdy_rand = 0;
    issue_ready = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset values
    #2 rst_n = 1'b0;
    #10;
    check8("rst_pc", pc_address, 8'h00);
    check8("rst_valid", {7'b0, issue_valid}, 8'h00);
    check8("rst_instr", issue_instr, 8'h00);
    check8("rst_halted", {7'b0, halted}, 8'h00);
    check8("rst_busy", {7'b0, busy}, 8'h00);
    reset_dut();
    step();

    // Sequential NOPs with wrap at FE; a start while busy is ignored.
    pulse_start();
    check8("seq_pc", pc_address, 8'h00);
    check8("seq_busy", {7'b0, busy}, 8'h01);
    for (int k = 1; k <= 129; k++) begin
      step();
      if (k == 3) start = 1'b1;
      step();
      start = 1'b0;
      check8("seq_pc", pc_address, 8'(2 * k));
      check8("seq_valid", {7'b0, issue_valid}, 8'h00);
      check8("seq_busy", {7'b0, busy}, 8'h01);
    end
    $display("sequential walk done pc=%h", pc_address);

    // Directed branch program ending in HALT at 12
    reg0_value = 8'h13;
    mem[8'h00] = 8'h31; mem[8'h02] = 8'h76; mem[8'h04] = 8'h40;
    mem[8'h06] = 8'h76; mem[8'h0C] = 8'h8E; mem[8'h0E] = 8'hDA;
    mem[8'h10] = 8'h8E; mem[8'h12] = 8'hFF;
    run_program(500);
    repeat (3) step();
    check8("halt_hold_halted", {7'b0, halted}, 8'h01);
    check8("halt_hold_pc", pc_address, 8'h12);
    check8("halt_hold_busy", {7'b0, busy}, 8'h00);
    pulse_start();
    check8("restart_pc", pc_address, 8'h00);
    check8("restart_halted", {7'b0, halted}, 8'h00);
    check8("restart_busy", {7'b0, busy}, 8'h01);

    // Explicit stall, then async reset during a second stall
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hDA;
    mem[8'h02] = 8'hDA;
    issue_ready = 1'b0;
    reset_dut();
    step();
    pulse_start();
    step();
    for (int s = 0; s < 3; s++) begin
      check8("stall3_valid", {7'b0, issue_valid}, 8'h01);
      check8("stall3_instr", issue_instr, 8'hDA);
      check8("stall3_pc", pc_address, 8'h00);
      step();
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    check8("accept_valid", {7'b0, issue_valid}, 8'h00);
    check8("accept_pc", pc_address, 8'h02);
    step();
    check8("stall2_valid", {7'b0, issue_valid}, 8'h01);
    #3 rst_n = 1'b0;
    #1;
    check8("async_valid", {7'b0, issue_valid}, 8'h00);
    check8("async_busy", {7'b0, busy}, 8'h00);
    check8("async_pc", pc_address, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    step();
    check8("idle_after_rst", {7'b0, busy}, 8'h00);

    // Randomized programs
    for (int r = 0; r < 30; r++) begin
      reg0_value = 8'($urandom);
      for (int i = 0; i < 256; i++) begin
        int w;
        logic [7:0] b;
        w = $urandom_range(0, 99);
        if (w < 15) b = 8'h00;
        else if (w < 18) b = 8'hFF;
        else if (w < 33) b = {4'h7, 4'($urandom)};
        else if (w < 48) b = {4'hA, 4'($urandom)};
        else if (w < 58) b = {4'h8, 4'($urandom)};
        else begin
          b = 8'($urandom);
          while (b == 8'h00 || b == 8'hFF || b[7:4] == 4'h7 ||
                 b[7:4] == 4'hA || b[7:4] == 4'h8) b = 8'($urandom);
        end
        mem[i] = b;
      end
      run_program(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Initiator side of the instruction-memory interface.
- Owns the program counter and drives the 8-bit fetch address to the combinational instruction memory, then latches the returned 8-bit instruction.
- Resolves all control flow (NOP, branches, HALT) locally.
- Hands every other instruction to the execute datapath over a valid/ready handshake.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset and on start.
- PC_STEP, 2, byte increment between sequential instructions.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins execution from IDLE or HALT.
- pc_address  output  8  fetch address to instruction memory.
- instr_in  input  8  instruction returned by memory, combinational from pc_address.
- issue_valid  output  1  issue_instr holds a datapath instruction.
- issue_instr  output  8  instruction handed to the datapath.
- issue_ready  input  1  datapath accepts when valid&&ready at a rising edge.
- acc_zero  input  1  datapath ACC==0 flag; registered in the datapath; reflects any accepted instruction by the next cycle.
- reg0_value  input  8  current register 0 contents, used as an indirect branch target.
- halted  output  1  high while in HALT.
- busy  output  1  high in FETCH or EXEC.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE, pc=RESET_PC, IR=8'h00, issue_valid=0, issue_instr=8'h00, halted=0, busy=0.
- Output sourcing:
  - pc_address = pc register, always.
  - issue_instr = IR.
  - All outputs are registered or derived only from state/IR. No combinational path from instr_in to any output.
- Decode, on IR:
  - 8'h00: NOP.
  - 8'hFF: HALT.
  - [7:4]=4'b0111: BZ imm. Taken if acc_zero=1; target={3'b000,IR[3:0],1'b0}.
  - [7:4]=4'b1010: BNZ imm. Taken if acc_zero=0; same target.
  - [7:4]=4'b1000: BNZ reg. Taken if acc_zero=0; target={reg0_value[7:1],1'b0}.
  - Anything else: datapath instruction, issued.
- States:
  - IDLE: wait. start -> pc=RESET_PC, go FETCH.
  - FETCH (1 cycle): IR<=instr_in; go EXEC.
  - EXEC:
    - NOP: pc<=pc+PC_STEP, go FETCH.
    - Branch: evaluate acc_zero this cycle. pc<=taken?target:pc+PC_STEP; go FETCH.
    - HALT: pc unchanged; go HALT; halted<=1.
    - Datapath instruction: assert issue_valid and hold IR stable until issue_ready. On acceptance: pc<=pc+PC_STEP, issue_valid<=0, go FETCH. No cycle limit on stall.
  - HALT: hold. start -> halted<=0, pc=RESET_PC, go FETCH. Other inputs are ignored.
- Latency:
  - NOP or branch: 2 cycles.
  - Datapath instruction with ready high: 2 cycles.
  - Each stall cycle adds 1 cycle.
- Hazard rule: the FETCH cycle between an accepted ALU instruction and a following branch's EXEC guarantees acc_zero is current. No extra interlock.
- Width rules:
  - pc+PC_STEP wraps modulo 256 (8'hFE -> 8'h00).
  - Branch targets are always even.
  - If pc is odd (e.g. RESET_PC odd), fetch proceeds anyway; no fault.
- Boundary conditions:
  - start while busy is ignored.
  - issue_ready while issue_valid=0 is ignored.
  - Reset asserted mid-handshake drops issue_valid immediately (asynchronous); state returns to IDLE.
  - A branch to its own address loops indefinitely; this is legal.
  - start and HALT decode in the same EXEC cycle: the HALT is taken and start is ignored.

Decomposition:
- Shared package, used by the assembler tests and the datapath decoder:
  - opcode constants: OP_NOP=8'h00, OP_HALT=8'hFF, OPC_BZ_IMM=4'b0111, OPC_BNZ_IMM=4'b1010, OPC_BNZ_REG=4'b1000.
  - State encoding: IDLE/FETCH/EXEC/HALT.
  - PC width constant = 8.
- One sub-module, next_pc_logic: combinational. Inputs are IR, pc, acc_zero and reg0_value. Outputs are next_pc, is_branch, is_halt, is_nop.

Test Plan:
- Sequential fetch: reset, start, memory all NOPs -> pc_address steps 00,02,04 every 2 cycles; issue_valid stays 0; busy=1.
- Branch taken: IR=8'h76 at pc 02, acc_zero=1 -> next pc_address=8'h0C. Not taken: same with acc_zero=0 -> 8'h04.
- Indirect branch: IR=8'h8E, acc_zero=0, reg0_value=8'h13 -> pc=8'h12. With acc_zero=1 -> pc+2.
- Stall: IR=8'hDA, issue_ready low 3 cycles -> issue_valid=1 and issue_instr=8'hDA held 3 cycles; pc advances only on the accept edge.
- HALT and restart: IR=8'hFF at pc 8'h12 -> halted=1, pc_address held at 8'h12. Then start -> pc_address=RESET_PC, halted=0.
- Wrap and reset: NOPs at pc 8'hFE -> next pc 8'h00. Assert rst_n low during issue stall -> issue_valid=0 asynchronously; state IDLE.
